ntt_out_serializer: RTL and testbench

Parallel-to-serial output stage for the NTT datapath. Accepts one full output vector of `INPUT_PER_CYCLE` coefficients per handshake from the NTT core side and streams it out one coefficient per cycle, lowest index first, on a valid/ready interface. A two-entry vector buffer lets the next vector land while the current one drains. It is the transmit-side counterpart of the serial-to-parallel input loading in the top-level wrapper, with real flow control in place of a free-running slot counter.

---
 rtl/ntt_out_serializer.sv | 104 ++++++++++
 tb/tb_ntt_out_serializer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ntt_out_serializer.sv
// Parallel-to-serial NTT output stage: two-entry vector buffer drained one coefficient per cycle.
// Optional out_last / per-polynomial vector counter enabled by defining NTT_SER_LAST_EN.
module ntt_out_serializer #(
   parameter int unsigned DATA_WIDTH_PER_INPUT = 28,
   parameter int unsigned INPUT_PER_CYCLE      = 32,
   parameter int unsigned VECTORS_PER_POLY     = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DATA_WIDTH_PER_INPUT-1:0] in_data [INPUT_PER_CYCLE-1:0],
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_WIDTH_PER_INPUT-1:0] out_data
`ifdef NTT_SER_LAST_EN
   ,
   output logic                            out_last
`endif
);

   localparam int unsigned IDX_W = $clog2(INPUT_PER_CYCLE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_PER_CYCLE - 1);

   if (INPUT_PER_CYCLE < 2 || (INPUT_PER_CYCLE & (INPUT_PER_CYCLE - 1)) != 0 ||
       VECTORS_PER_POLY < 1) begin : g_bad_params
      $error("ntt_out_serializer: invalid parameters");
   end

   logic [DATA_WIDTH_PER_INPUT-1:0] r_buf [2][INPUT_PER_CYCLE-1:0];
   logic                            r_wr_ptr;
   logic                            r_rd_ptr;
   logic [1:0]                      r_count;
   logic [IDX_W-1:0]                r_word_idx;

   logic                            w_accept;
   logic                            w_xfer;
   logic                            w_retire;
   logic [1:0]                      w_count_nxt;

   // Handshake decode uses registered count only, so a full buffer never passes through.
   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign out_data  = r_buf[r_rd_ptr][r_word_idx];

   assign w_accept  = in_valid && in_ready;
   assign w_xfer    = out_valid && out_ready;
   assign w_retire  = w_xfer && (r_word_idx == LAST_IDX);

   always_comb begin
      w_count_nxt = r_count;
      if (w_accept && !w_retire) begin
         w_count_nxt = r_count + 2'd1;
      end else if (!w_accept && w_retire) begin
         w_count_nxt = r_count - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_buf[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= '0;
         r_word_idx <= '0;
      end else begin
         r_count <= w_count_nxt;
         if (w_accept) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_xfer) begin
            if (w_retire) begin
               r_word_idx <= '0;
               r_rd_ptr   <= ~r_rd_ptr;
            end else begin
               r_word_idx <= r_word_idx + 1'b1;
            end
         end
      end
   end

`ifdef NTT_SER_LAST_EN
   localparam int unsigned VC_W = (VECTORS_PER_POLY > 1) ? $clog2(VECTORS_PER_POLY) : 1;
   localparam logic [VC_W-1:0] LAST_VEC = VC_W'(VECTORS_PER_POLY - 1);

   logic [VC_W-1:0] r_vec_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vec_cnt <= '0;
      end else if (w_retire) begin
         r_vec_cnt <= (r_vec_cnt == LAST_VEC) ? '0 : r_vec_cnt + 1'b1;
      end
   end

   assign out_last = out_valid && (r_word_idx == LAST_IDX) && (r_vec_cnt == LAST_VEC);
`endif

endmodule

// File: tb/tb_ntt_out_serializer.sv
// Randomized bench for ntt_out_serializer against a queue-of-vectors reference model.
// Checks out_last as well when NTT_SER_LAST_EN is defined.
module tb_ntt_out_serializer;

   localparam int W   = 28;
   localparam int N   = 32;
   localparam int VPP = 16;

   typedef logic [W-1:0] vec_t [N-1:0];

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   vec_t         in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
`ifdef NTT_SER_LAST_EN
   logic         out_last;
`endif

   ntt_out_serializer #(
      .DATA_WIDTH_PER_INPUT(W),
      .INPUT_PER_CYCLE     (N),
      .VECTORS_PER_POLY    (VPP)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data)
`ifdef NTT_SER_LAST_EN
      ,
      .out_last (out_last)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: queue of buffered vectors, read position in head, retired-vector count.
   vec_t         mq[$];
   int           mpos;
   int           mvec;
   logic         p_valid;
   logic         p_ready;
   logic [W-1:0] p_data;

   int n_chk;
   int n_pass;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic check_outputs();
      check("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
      check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      if (mq.size() > 0) check("out_data", {4'd0, out_data}, {4'd0, mq[0][mpos]});
      if (p_valid && !p_ready) check("stable", {4'd0, out_data}, {4'd0, p_data});
`ifdef NTT_SER_LAST_EN
      check("out_last", {31'd0, out_last},
            {31'd0, (mq.size() > 0) && (mpos == N - 1) && ((mvec % VPP) == VPP - 1)});
`endif
   endtask

   // Called at a negedge with inputs already driven; advances one clock and checks.
   task automatic tick(output bit acc);
      bit xfer;
      acc     = in_valid && rst && (mq.size() < 2);
      xfer    = out_ready && rst && (mq.size() > 0);
      p_valid = out_valid;
      p_ready = out_ready;
      p_data  = out_data;
      @(posedge clk);
      if (xfer) begin
         mpos++;
         if (mpos == N) begin
            void'(mq.pop_front());
            mpos = 0;
            mvec++;
         end
      end
      if (acc) mq.push_back(in_data);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic mk(output vec_t v, input int idx, input bit seq);
      for (int i = 0; i < N; i++)
         v[i] = seq ? W'(i + 100 + N * idx) : W'($urandom);
   endtask

   task automatic clear_model();
      mq.delete();
      mpos    = 0;
      mvec    = 0;
      p_valid = 1'b0;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b0;
      clear_model();
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef NTT_SER_LAST_EN
      check("rst_out_last", {31'd0, out_last}, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic stream(input int nvec, input int ready_pct, input int hold_off, input bit seq);
      vec_t v;
      vec_t junk;
      int   sent;
      int   cyc;
      bit   acc;
      sent = 0;
      cyc  = 0;
      mk(v, 0, seq);
      while ((sent < nvec || mq.size() != 0) && cyc < 4000) begin
         if (sent < nvec) begin
            in_valid = 1'b1;
            in_data  = v;
         end else begin
            in_valid = 1'b0;
            mk(junk, 0, 1'b0);
            in_data  = junk;
         end
         out_ready = (cyc < hold_off) ? 1'b0 : ($urandom_range(99) < ready_pct);
         tick(acc);
         if (acc) begin
            sent++;
            if (sent < nvec) mk(v, sent, seq);
         end
         cyc++;
      end
      in_valid = 1'b0;
      check("stream_done", {31'd0, (sent == nvec) && (mq.size() == 0)}, 32'd1);
   endtask

   initial begin
      vec_t v;
      bit   acc;
      int   guard;
      n_chk    = 0;
      n_pass   = 0;
      rst      = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      mk(v, 0, 1'b1);
      in_data  = v;
      @(negedge clk);
      do_reset();

      // single vector 100..131, then back-to-back pair
      stream(1, 100, 0, 1'b1);
      stream(2, 100, 0, 1'b0);
      // fill with out_ready low: third vector waits until the head retires
      stream(3, 100, 6, 1'b0);
      // random backpressure
      stream(4, 50, 0, 1'b0);
      stream(4, 25, 3, 1'b1);

      // reset mid-stream after word 10
      mk(v, 0, 1'b0);
      in_data   = v;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick(acc);
      in_valid = 1'b0;
      guard = 0;
      while (mpos < 11 && guard < 100) begin
         tick(acc);
         guard++;
      end
      check("mid_pos", mpos, 11);
      rst = 1'b0;
      #1;
      check("mid_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_in_ready", {31'd0, in_ready}, 32'd1);
      clear_model();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      stream(1, 100, 0, 1'b1);

      do_reset();
      stream(32, 100, 0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
